// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The overflow output V exists only when OVERFLOW_FLAG_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             busy;
    logic             done;
`ifdef OVERFLOW_FLAG_EN
    logic             V;
`endif

    modport master (
        output start, A, B, Bin,
`ifdef OVERFLOW_FLAG_EN
        input  V,
`endif
        input  D, Bout, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
`ifdef OVERFLOW_FLAG_EN
        output V,
`endif
        output D, Bout, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, one full-subtractor cell, LSB first; OVERFLOW_FLAG_EN adds V.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is only accepted in IDLE or DONE; start while busy is dropped.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_subtractor_if.slave   sub
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] r_full;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             borrow_nxt;
    logic             d_bit;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
`ifdef OVERFLOW_FLAG_EN
    logic             a_msb;
    logic             b_msb;
    logic             v_q;
`endif

    always_comb begin
        accept     = sub.start && ((state == IDLE) || (state == DONE));
        last       = (state == RUN) && (count == CW'(WIDTH - 1));
        d_bit      = a_sh[0] ^ b_sh[0] ^ borrow;
        borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        // The new bit enters at the MSB; after WIDTH shifts r_full is the whole result.
        r_full     = {d_bit, r_sh};
        state_nxt  = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            count  <= '0;
            borrow <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            v_q    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh   <= sub.A;
                b_sh   <= sub.B;
                borrow <= sub.Bin;
                count  <= '0;
`ifdef OVERFLOW_FLAG_EN
                a_msb  <= sub.A[WIDTH-1];
                b_msb  <= sub.B[WIDTH-1];
`endif
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                borrow <= borrow_nxt;
                r_sh   <= r_full[WIDTH-1:1];
                count  <= count + CW'(1);
                // Results only move on completion, so they stay valid across a new start.
                if (last) begin
                    d_q    <= r_full;
                    bout_q <= borrow_nxt;
`ifdef OVERFLOW_FLAG_EN
                    v_q    <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                end
            end
        end
    end

    assign sub.D    = d_q;
    assign sub.Bout = bout_q;
    assign sub.busy = (state == RUN);
    assign sub.done = (state == DONE);
`ifdef OVERFLOW_FLAG_EN
    assign sub.V    = v_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: vector table, multi-cycle corner sequences, random ops vs arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) sif();
    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .sub   (sif)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain unsigned arithmetic on integers.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                  output logic [7:0] d, output logic bout, output logic v);
        int r;
        r    = int'(a) - int'(b) - int'(bin);
        bout = (r < 0);
        d    = r[7:0];
        v    = (a[7] ^ b[7]) & (a[7] ^ d[7]);
    endfunction

    function automatic logic read_v();
`ifdef OVERFLOW_FLAG_EN
        return sif.V;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge. poke>0 raises a spurious start with junk operands in that RUN cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input int poke,
                          output logic [7:0] d, output logic bout, output logic v,
                          output int lat, output int busy_n);
        sif.start = 1'b1;
        sif.A = a;
        sif.B = b;
        sif.Bin = bin;
        lat = 0; busy_n = 0; d = '0; bout = 1'b0; v = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            sif.start = (poke != 0) && (c == poke);
            sif.A = 8'($urandom);
            sif.B = 8'($urandom);
            sif.Bin = 1'($urandom);
            if (sif.busy) busy_n++;
            if (sif.done) begin
                lat = c; d = sif.D; bout = sif.Bout; v = read_v();
                break;
            end
        end
        sif.start = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] gd, ed;
        logic gb, eb, gv, ev;
        int lat, bn, ndone;
        logic prev_done;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'h22, 8'h22, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};

        reset = 1'b1;
        sif.start = 1'b0; sif.A = '0; sif.B = '0; sif.Bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_D", 32'(sif.D), 32'h00);
        check("rst_Bout", 32'(sif.Bout), 0);
        check("rst_busy", 32'(sif.busy), 0);
        check("rst_done", 32'(sif.done), 0);
`ifdef OVERFLOW_FLAG_EN
        check("rst_V", 32'(sif.V), 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(sif.busy), 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, gd, gb, gv, lat, bn);
            check($sformatf("vec%0d_D", i), 32'(gd), 32'(vecs[i].d));
            check($sformatf("vec%0d_Bout", i), 32'(gb), 32'(vecs[i].bout));
            check($sformatf("vec%0d_latency", i), lat, 9);
            check($sformatf("vec%0d_busy_cycles", i), bn, 8);
            @(negedge clk);
            check($sformatf("vec%0d_D_held", i), 32'(sif.D), 32'(vecs[i].d));
            check($sformatf("vec%0d_done_width", i), 32'(sif.done), 0);
        end

        // Spurious start in RUN cycle 3 must be ignored.
        run_op(8'h80, 8'h01, 1'b0, 3, gd, gb, gv, lat, bn);
        check("ign_D", 32'(gd), 32'h7F);
        check("ign_Bout", 32'(gb), 0);
        check("ign_latency", lat, 9);
`ifdef OVERFLOW_FLAG_EN
        check("ign_V", 32'(gv), 1);
`endif
        @(negedge clk);
        check("ign_no_restart", 32'(sif.busy), 0);

        // Start held high: a result every 9 cycles, done one cycle wide.
        sif.start = 1'b1; sif.A = 8'h05; sif.B = 8'h03; sif.Bin = 1'b0;
        ndone = 0; prev_done = 1'b0;
        for (int c = 1; c <= 37; c++) begin
            @(negedge clk);
            if (prev_done) check("held_done_width", 32'(sif.done), 0);
            if (sif.done) begin
                ndone++;
                check("held_period", c, 9 * ndone);
                check("held_D", 32'(sif.D), 32'h02);
                check("held_Bout", 32'(sif.Bout), 0);
            end
            prev_done = sif.done;
        end
        sif.start = 1'b0;
        check("held_count", ndone, 4);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (sif.done) begin lat = c; break; end
        end
        check("held_drain", lat, 8);
        @(negedge clk);

        // Reset in RUN cycle 4 aborts without a done pulse.
        sif.start = 1'b1; sif.A = 8'h5A; sif.B = 8'h3C; sif.Bin = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            sif.start = 1'b0;
            if (c == 4) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        check("abort_D", 32'(sif.D), 32'h00);
        check("abort_Bout", 32'(sif.Bout), 0);
        check("abort_busy", 32'(sif.busy), 0);
        check("abort_done", 32'(sif.done), 0);
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (sif.done || sif.busy) ndone++;
        end
        check("abort_quiet", ndone, 0);
        run_op(8'h5A, 8'h3C, 1'b0, 0, gd, gb, gv, lat, bn);
        check("after_abort_D", 32'(gd), 32'h1E);
        check("after_abort_Bout", 32'(gb), 0);
        check("after_abort_latency", lat, 9);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            model(ra, rb, rbin, ed, eb, ev);
            run_op(ra, rb, rbin, $urandom_range(0, 7), gd, gb, gv, lat, bn);
            check($sformatf("rnd%0d_D", i), 32'(gd), 32'(ed));
            check($sformatf("rnd%0d_Bout", i), 32'(gb), 32'(eb));
            check($sformatf("rnd%0d_latency", i), lat, 9);
`ifdef OVERFLOW_FLAG_EN
            check($sformatf("rnd%0d_V", i), 32'(gv), 32'(ev));
`endif
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
